// File: rtl/mac_4x4_pkg.sv
// mac_4x4_pkg: shared widths, PE count and saturation constant for the 2x2 systolic MAC array.
// Optional saturation is selected with the MAC_4X4_SAT_EN macro.
package mac_4x4_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ACC_W_DEF  = 64;
    localparam int PE_N       = 4;
    localparam int PE_COLS    = 2;
    localparam logic [255:0] ACC_MAX_ALL = '1;
endpackage

// File: rtl/mac_4x4_array_pe.sv
// mac_pe: one output-stationary PE with multiply, accumulate and A/B forwarding registers.
// MAC_4X4_SAT_EN defined: accumulator clamps at all-ones instead of wrapping.
module mac_pe
    import mac_4x4_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [ACC_W-1:0]  acc_o,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o
);
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [DATA_W-1:0]   a_q, b_q;
    assign prod = a_i * b_i;
`ifdef MAC_4X4_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = ACC_MAX_ALL[ACC_W-1:0];
    logic [ACC_W:0] sum;
    // Carry out of the widened sum means overflow; clamping keeps the max sticky.
    assign sum   = {1'b0, acc_q} + (ACC_W+1)'(prod);
    assign acc_d = sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0];
`else
    assign acc_d = acc_q + ACC_W'(prod);
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            acc_q <= acc_d;
            a_q   <= a_i;
            b_q   <= b_i;
        end
    end
    assign acc_o = acc_q;
    assign a_o   = a_q;
    assign b_o   = b_q;
endmodule

// File: rtl/mac_4x4_array.sv
// mac_4x4_array: 2x2 output-stationary systolic MAC mesh; A flows right, B flows down, no input skew.
// Build with MAC_4X4_SAT_EN to make every accumulator saturate instead of wrap.
module mac_4x4_array
    import mac_4x4_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_a0,
    input  logic [DATA_W-1:0] in_a1,
    input  logic [DATA_W-1:0] in_b0,
    input  logic [DATA_W-1:0] in_b1,
    output logic [ACC_W-1:0]  o00,
    output logic [ACC_W-1:0]  o01,
    output logic [ACC_W-1:0]  o10,
    output logic [ACC_W-1:0]  o11
);
    logic [DATA_W-1:0] a_in  [PE_N];
    logic [DATA_W-1:0] b_in  [PE_N];
    logic [DATA_W-1:0] a_fwd [PE_N];
    logic [DATA_W-1:0] b_fwd [PE_N];
    logic [ACC_W-1:0]  acc   [PE_N];
    logic [DATA_W-1:0] edge_a [PE_COLS];
    logic [DATA_W-1:0] edge_b [PE_COLS];
    assign edge_a[0] = in_a0;
    assign edge_a[1] = in_a1;
    assign edge_b[0] = in_b0;
    assign edge_b[1] = in_b1;
    // PE index g = row*PE_COLS + col; left column takes row inputs, top row takes column inputs.
    for (genvar g = 0; g < PE_N; g++) begin : g_pe
        localparam int ROW = g / PE_COLS;
        localparam int COL = g % PE_COLS;
        if (COL == 0) begin : g_a_edge
            assign a_in[g] = edge_a[ROW];
        end else begin : g_a_mesh
            assign a_in[g] = a_fwd[g-1];
        end
        if (ROW == 0) begin : g_b_edge
            assign b_in[g] = edge_b[COL];
        end else begin : g_b_mesh
            assign b_in[g] = b_fwd[g-PE_COLS];
        end
        mac_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
            .clk   (clk),
            .rst_n (rst),
            .a_i   (a_in[g]),
            .b_i   (b_in[g]),
            .acc_o (acc[g]),
            .a_o   (a_fwd[g]),
            .b_o   (b_fwd[g])
        );
    end
    assign o00 = acc[0];
    assign o01 = acc[1];
    assign o10 = acc[2];
    assign o11 = acc[3];
endmodule

// File: tb/tb_mac_4x4_array.sv
// tb_mac_4x4_array: directed + randomized check of the 2x2 systolic MAC against a delay-line model.
// Define MAC_4X4_SAT_EN for both RTL and bench to check the saturating build.
module tb_mac_4x4_array;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in_a0 = '0, in_a1 = '0, in_b0 = '0, in_b1 = '0;
    logic [63:0] o00, o01, o10, o11;
    int n_cmp = 0;
    int n_bad = 0;
    // Model: PE(i,j) sees a_i delayed j cycles and b_j delayed i cycles.
    logic [63:0] m [4];
    logic [31:0] pa [2];
    logic [31:0] pb [2];

    mac_4x4_array dut (
        .clk(clk), .rst(rst),
        .in_a0(in_a0), .in_a1(in_a1), .in_b0(in_b0), .in_b1(in_b1),
        .o00(o00), .o01(o01), .o10(o10), .o11(o11)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".o00"}, o00, m[0]);
        chk({tag, ".o01"}, o01, m[1]);
        chk({tag, ".o10"}, o10, m[2]);
        chk({tag, ".o11"}, o11, m[3]);
    endtask

    task automatic chk4(input string tag, input logic [63:0] e0, e1, e2, e3);
        chk({tag, ".o00"}, o00, e0);
        chk({tag, ".o01"}, o01, e1);
        chk({tag, ".o10"}, o10, e2);
        chk({tag, ".o11"}, o11, e3);
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++) m[k] = '0;
        pa[0] = '0; pa[1] = '0; pb[0] = '0; pb[1] = '0;
    endtask

    task automatic model_edge();
        logic [31:0] ca [2];
        logic [31:0] cb [2];
        logic [31:0] av, bv;
        logic [64:0] s;
        ca[0] = in_a0; ca[1] = in_a1; cb[0] = in_b0; cb[1] = in_b1;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                av = (j == 0) ? ca[i] : pa[i];
                bv = (i == 0) ? cb[j] : pb[j];
                s = {1'b0, m[2*i+j]} + 65'({32'b0, av} * {32'b0, bv});
`ifdef MAC_4X4_SAT_EN
                m[2*i+j] = s[64] ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
`else
                m[2*i+j] = s[63:0];
`endif
            end
        pa = ca;
        pb = cb;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk_all(tag);
    endtask

    task automatic drive(input logic [31:0] a0, a1, b0, b1);
        in_a0 = a0; in_a1 = a1; in_b0 = b0; in_b1 = b1;
    endtask

    task automatic do_reset(input string tag);
        #2 rst = 1'b0;
        #1;
        chk4(tag, 64'd0, 64'd0, 64'd0, 64'd0);
        model_clear();
        #1 rst = 1'b1;
    endtask

    task automatic step2_seq(input string tag);
        drive(32'd10, 32'd5, 32'd2, 32'd3);
        @(posedge clk); model_edge(); #1; chk4({tag, ".e1"}, 64'd20, 64'd0, 64'd0, 64'd0);
        @(posedge clk); model_edge(); #1; chk4({tag, ".e2"}, 64'd40, 64'd30, 64'd10, 64'd15);
        @(posedge clk); model_edge(); #1; chk4({tag, ".e3"}, 64'd60, 64'd60, 64'd20, 64'd30);
    endtask

    initial begin
        model_clear();
        #3;
        chk4("reset_init", 64'd0, 64'd0, 64'd0, 64'd0);
        @(posedge clk); #1;
        chk4("reset_held", 64'd0, 64'd0, 64'd0, 64'd0);
        #2 rst = 1'b1;
        step2_seq("seq");
        for (int k = 0; k < 3; k++) step("steady");
        drive(0, 0, 0, 0);
        for (int k = 0; k < 4; k++) step("zero_flush");
        for (int k = 0; k < 40; k++) begin
            drive($urandom, $urandom, $urandom, $urandom);
            step("rand");
        end
        do_reset("reset_mid");
        drive(32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd0);
        step("max1");
        step("max2");
`ifdef MAC_4X4_SAT_EN
        chk("max_o00", o00, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        chk("max_o00", o00, 64'hFFFF_FFFC_0000_0002);
`endif
        for (int k = 0; k < 4; k++) step("max_more");
        for (int k = 0; k < 20; k++) begin
            drive($urandom, $urandom, $urandom, $urandom);
            step("rand2");
        end
        do_reset("reset_again");
        step2_seq("seq_again");
        for (int k = 0; k < 2; k++) step("steady_again");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
